// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks pending register writes, gates issue on RAW/WAW hazards
// and the in-flight limit, and quiesces the pipeline on a drain request.
module reg_scoreboard #(
  parameter int unsigned MAX_OUT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rs1,
  input  logic [4:0]  issue_rs2,
  input  logic [4:0]  issue_rd,
  input  logic        issue_wr,
  output logic        issue_ready,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        flush,
  input  logic        drain_req,
  output logic        drain_done,
  output logic [31:0] busy_mask,
  output logic [2:0]  outstanding,
  output logic [15:0] stall_count
);

  localparam int unsigned CNT_W     = 3;
  localparam logic [CNT_W-1:0] MAX_OUT_W = CNT_W'(MAX_OUT);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t             state;
  logic               wb_clear;
  logic               issue_set;
  logic               ready_c;
  logic [CNT_W-1:0]   out_after_wb;
  logic [31:0]        clr_mask;
  logic [31:0]        set_mask;
  logic [31:0]        busy_nxt;
  logic [CNT_W-1:0]   out_nxt;

  // A busy register stops being a hazard in the cycle its write-back lands (WB forwarding).
  function automatic logic hazard(input logic [4:0] r, input logic [31:0] busy,
                                  input logic wbv, input logic [4:0] wbr);
    return (r != 5'd0) && busy[r] && !(wbv && (wbr == r));
  endfunction

  always_comb begin
    wb_clear     = wb_valid && (wb_rd != 5'd0) && busy_mask[wb_rd];
    out_after_wb = outstanding - CNT_W'(wb_clear);
    ready_c      = !reset && !flush && (state == RUN)
                   && !hazard(issue_rs1, busy_mask, wb_valid, wb_rd)
                   && !hazard(issue_rs2, busy_mask, wb_valid, wb_rd)
                   && !(issue_wr && hazard(issue_rd, busy_mask, wb_valid, wb_rd))
                   && !(issue_wr && (out_after_wb >= MAX_OUT_W));
    issue_set    = issue_valid && ready_c && issue_wr && (issue_rd != 5'd0);
    clr_mask     = wb_clear  ? (32'd1 << wb_rd)    : 32'd0;
    set_mask     = issue_set ? (32'd1 << issue_rd) : 32'd0;
    // Set is applied after clear so a same-register issue/WB pair leaves the bit set.
    busy_nxt     = flush ? 32'd0 : (((busy_mask & ~clr_mask) | set_mask) & ~32'd1);
    out_nxt      = flush ? '0 : (outstanding + CNT_W'(issue_set) - CNT_W'(wb_clear));
  end

  assign issue_ready = ready_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      busy_mask   <= 32'd0;
      outstanding <= '0;
      stall_count <= 16'd0;
      drain_done  <= 1'b0;
    end else begin
      busy_mask   <= busy_nxt;
      outstanding <= out_nxt;
      drain_done  <= 1'b0;
      if (issue_valid && !ready_c && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
      case (state)
        RUN:   if (drain_req) state <= DRAIN;
        DRAIN: if (out_nxt == '0) begin
                 state      <= DONE;
                 drain_done <= 1'b1;
               end
        DONE:  state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Table-driven bench for reg_scoreboard: per-cycle stimulus records carry their expected
// outputs, queued at drive time and compared after the clock edge.
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        issue_wr;
  logic        issue_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic        drain_req;
  logic        drain_done;
  logic [31:0] busy_mask;
  logic [2:0]  outstanding;
  logic [15:0] stall_count;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  reg_scoreboard #(.MAX_OUT(4)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .issue_wr(issue_wr), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush), .drain_req(drain_req),
    .drain_done(drain_done), .busy_mask(busy_mask), .outstanding(outstanding),
    .stall_count(stall_count)
  );

  typedef struct {
    logic        rst, iv;
    logic [4:0]  rs1, rs2, rd;
    logic        wr, wbv;
    logic [4:0]  wbrd;
    logic        fl, dr;
    logic        rdy;
    logic [31:0] busy;
    logic [2:0]  outs;
    logic [15:0] stall;
    logic        done;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  function automatic vec_t mk(input logic rst, iv, input int rs1, rs2, rd, input logic wr, wbv,
                              input int wbrd, input logic fl, dr, rdy, input logic [31:0] busy,
                              input int outs, stall, input logic done);
    vec_t v;
    v.rst = rst; v.iv = iv; v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd);
    v.wr = wr; v.wbv = wbv; v.wbrd = 5'(wbrd); v.fl = fl; v.dr = dr;
    v.rdy = rdy; v.busy = busy; v.outs = 3'(outs); v.stall = 16'(stall); v.done = done;
    return v;
  endfunction

  task automatic check(input string name, input int row, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      failed++;
      $display("FAIL %s row %0d: got %h want %h", name, row, got, want);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; issue_valid = v.iv; issue_rs1 = v.rs1; issue_rs2 = v.rs2; issue_rd = v.rd;
    issue_wr = v.wr; wb_valid = v.wbv; wb_rd = v.wbrd; flush = v.fl; drain_req = v.dr;
  endtask

  initial begin
    vec_t e;
    int   pulses;
    //           rst iv rs1 rs2 rd wr wbv wbrd fl dr  rdy busy         outs stall done
    vecs.push_back(mk(1, 1, 0, 0, 3, 1, 0, 0, 0, 0,  0, 32'h0000_0000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 5, 1, 0, 0, 0, 0,  1, 32'h0000_0020, 1, 0, 0));
    vecs.push_back(mk(0, 1, 5, 0, 0, 0, 0, 0, 0, 0,  0, 32'h0000_0020, 1, 1, 0));
    vecs.push_back(mk(0, 1, 5, 0, 0, 0, 1, 5, 0, 0,  1, 32'h0000_0000, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0, 0, 0,  1, 32'h0000_0002, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 2, 1, 0, 0, 0, 0,  1, 32'h0000_0006, 2, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 3, 1, 0, 0, 0, 0,  1, 32'h0000_000E, 3, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 4, 1, 0, 0, 0, 0,  1, 32'h0000_001E, 4, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 6, 1, 0, 0, 0, 0,  0, 32'h0000_001E, 4, 2, 0));
    vecs.push_back(mk(0, 1, 6, 7, 0, 0, 0, 0, 0, 0,  1, 32'h0000_001E, 4, 2, 0));
    vecs.push_back(mk(0, 1, 0, 0, 6, 1, 1, 1, 0, 0,  1, 32'h0000_005C, 4, 2, 0));
    vecs.push_back(mk(0, 1, 0, 0, 2, 1, 0, 0, 0, 0,  0, 32'h0000_005C, 4, 3, 0));
    vecs.push_back(mk(0, 1, 0, 0, 7, 1, 1, 2, 1, 0,  0, 32'h0000_0000, 0, 4, 0));
    vecs.push_back(mk(0, 1, 0, 0, 7, 1, 0, 0, 0, 0,  1, 32'h0000_0080, 1, 4, 0));
    vecs.push_back(mk(0, 1, 0, 0, 7, 1, 1, 7, 0, 0,  1, 32'h0000_0080, 1, 4, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0,  1, 32'h0000_0080, 1, 4, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 9, 0, 0,  1, 32'h0000_0080, 1, 4, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8, 1, 0, 0, 0, 0,  1, 32'h0000_0180, 2, 4, 0));
    vecs.push_back(mk(0, 1, 0, 0, 9, 1, 0, 0, 0, 0,  1, 32'h0000_0380, 3, 4, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1,  1, 32'h0000_0380, 3, 4, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 7, 0, 0,  0, 32'h0000_0300, 2, 5, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 8, 0, 0,  0, 32'h0000_0200, 1, 5, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 9, 0, 0,  0, 32'h0000_0000, 0, 5, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1,  0, 32'h0000_0000, 0, 6, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 32'h0000_0000, 0, 6, 0));
    vecs.push_back(mk(0, 1, 0, 0,10, 1, 0, 0, 0, 0,  1, 32'h0000_0400, 1, 6, 0));
    vecs.push_back(mk(0, 1, 0, 0,11, 1, 0, 0, 0, 0,  1, 32'h0000_0C00, 2, 6, 0));
    vecs.push_back(mk(0, 1, 0, 0,12, 1, 0, 0, 0, 0,  1, 32'h0000_1C00, 3, 6, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 32'h0000_1C00, 3, 6, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 32'h0000_0000, 0, 6, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h0000_0000, 0, 6, 0));
    vecs.push_back(mk(0, 1, 0, 0,13, 1, 0, 0, 0, 0,  1, 32'h0000_2000, 1, 6, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 32'h0000_2000, 1, 6, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1,13, 0, 0,  0, 32'h0000_0000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 32'h0000_0000, 0, 0, 0));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      exp_q.push_back(vecs[i]);
      #1;
      if (!vecs[i].rst || i == 0) check("issue_ready", i, 32'(issue_ready), 32'(vecs[i].rdy));
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check("busy_mask",   i, busy_mask,          e.busy);
      check("outstanding", i, 32'(outstanding),   32'(e.outs));
      check("stall_count", i, 32'(stall_count),   32'(e.stall));
      check("drain_done",  i, 32'(drain_done),    32'(e.done));
    end

    // Drain with nothing pending: exactly one drain_done pulse, then back to RUN.
    @(negedge clk);
    issue_valid = 1'b1; issue_rs1 = 5'd0; issue_rs2 = 5'd0; issue_rd = 5'd0; issue_wr = 1'b0;
    wb_valid = 1'b0; flush = 1'b0; reset = 1'b0; drain_req = 1'b1;
    #1 check("ready_before_drain", 100, 32'(issue_ready), 32'd1);
    @(negedge clk);
    drain_req = 1'b0;
    #1 check("ready_in_drain", 101, 32'(issue_ready), 32'd0);
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (drain_done) pulses++;
    end
    check("empty_drain_pulses", 102, 32'(pulses), 32'd1);
    @(negedge clk);
    #1 check("ready_after_drain", 103, 32'(issue_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
